// File: rtl/alu_mc_if.sv
// alu_mc_if: issue/result bundle between the EX-stage controller and alu_mc.
//   master (controller): drives start, op, a, b; observes busy, done, c, zero, ovf, hi, lo
//   slave  (alu_mc)    : the mirror image
// WIDTH/OPW must match the parameters of the alu_mc instance it connects to.
interface alu_mc_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 5
);
    logic             start;
    logic [OPW-1:0]   op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] c;
    logic             zero;
    logic             ovf;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b,
                    input  busy, done, c, zero, ovf, hi, lo);
    modport slave  (input  start, op, a, b,
                    output busy, done, c, zero, ovf, hi, lo);
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle MIPS EX-stage ALU.
//   clk, rstn : rising-edge clock, asynchronous active-low reset
//   bus       : alu_mc_if.slave -- start/op/a/b in; busy/done/c/zero/ovf/hi/lo out
// Single-cycle ops register c/zero/ovf on the issue edge and pulse done the
// following cycle. MULT/MULTU/DIV/DIVU iterate one bit per cycle for WIDTH
// cycles, then spend one FIX cycle applying signs before writing hi/lo.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int OPW   = 5,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic     clk,
    input  logic     rstn,
    alu_mc_if.slave  bus
);
    localparam logic [OPW-1:0] OP_ADD   = OPW'(1);
    localparam logic [OPW-1:0] OP_ADDU  = OPW'(2);
    localparam logic [OPW-1:0] OP_SUB   = OPW'(3);
    localparam logic [OPW-1:0] OP_SUBU  = OPW'(4);
    localparam logic [OPW-1:0] OP_SLT   = OPW'(5);
    localparam logic [OPW-1:0] OP_SLTU  = OPW'(6);
    localparam logic [OPW-1:0] OP_AND   = OPW'(7);
    localparam logic [OPW-1:0] OP_OR    = OPW'(8);
    localparam logic [OPW-1:0] OP_XOR   = OPW'(9);
    localparam logic [OPW-1:0] OP_NOR   = OPW'(10);
    localparam logic [OPW-1:0] OP_SLL   = OPW'(11);
    localparam logic [OPW-1:0] OP_SRL   = OPW'(12);
    localparam logic [OPW-1:0] OP_SRA   = OPW'(13);
    localparam logic [OPW-1:0] OP_EQ    = OPW'(14);
    localparam logic [OPW-1:0] OP_MULT  = OPW'(16);
    localparam logic [OPW-1:0] OP_MULTU = OPW'(17);
    localparam logic [OPW-1:0] OP_DIV   = OPW'(18);
    localparam logic [OPW-1:0] OP_DIVU  = OPW'(19);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;

    state_e           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;   // MUL: upper product; DIV: partial remainder
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;   // MUL: multiplier/lower product; DIV: dividend/quotient
    logic [WIDTH-1:0] opnd_q, opnd_d;       // MUL: multiplicand; DIV: divisor
    logic             neg_a_q, neg_a_d, neg_b_q, neg_b_d, is_div_q, is_div_d;
    logic [WIDTH-1:0] c_q, c_d, hi_q, hi_d, lo_q, lo_d;
    logic             zero_q, zero_d, ovf_q, ovf_d, done_q, done_d;

    // ---------------- single-cycle datapath ----------------
    logic [WIDTH-1:0] alu_res, add_r, sub_r;
    logic             alu_ovf;
    logic [SHW-1:0]   shamt;

    always_comb begin
        add_r   = bus.a + bus.b;
        sub_r   = bus.a - bus.b;
        shamt   = bus.a[SHW-1:0];
        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus.op)
            OP_ADD: begin
                alu_res = add_r;
                alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_r[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_ADDU: alu_res = add_r;
            OP_SUB: begin
                alu_res = sub_r;
                alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_r[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUBU: alu_res = sub_r;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            OP_AND:  alu_res = bus.a & bus.b;
            OP_OR:   alu_res = bus.a | bus.b;
            OP_XOR:  alu_res = bus.a ^ bus.b;
            OP_NOR:  alu_res = ~(bus.a | bus.b);
            OP_SLL:  alu_res = bus.b << shamt;
            OP_SRL:  alu_res = bus.b >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(bus.b) >>> shamt);
            OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, (bus.a == bus.b)};
            default: alu_res = '0;   // NOP and unassigned codes
        endcase
    end

    // ---------------- iterative datapath ----------------
    logic             is_mul_op, is_div_op, signed_op;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   mul_sum, div_r;
    logic [WIDTH-1:0] div_diff, q_fix, r_fix;
    logic             div_ge;
    logic [2*WIDTH-1:0] prod_fix;

    always_comb begin
        is_mul_op = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
        is_div_op = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
        signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        abs_a     = (signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        abs_b     = (signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;

        // Shift-add: conditionally add multiplicand to the upper half, then
        // shift the whole {carry, hi, lo} right by one.
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);

        // Restoring divide: shift next dividend bit into the remainder. The
        // remainder is always < divisor, so the difference fits in WIDTH bits.
        div_r     = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_ge    = div_r >= {1'b0, opnd_q};
        div_diff  = div_r[WIDTH-1:0] - opnd_q;

        prod_fix  = (neg_a_q ^ neg_b_q) ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
        // Divide by zero leaves an all-ones quotient; keep it unsigned-looking.
        q_fix     = ((neg_a_q ^ neg_b_q) && (opnd_q != '0)) ? -acc_lo_q : acc_lo_q;
        r_fix     = neg_a_q ? -acc_hi_q : acc_hi_q;
    end

    // ---------------- control ----------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        is_div_d = is_div_q;
        c_d      = c_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (is_mul_op || is_div_op) begin
                        neg_a_d  = signed_op && bus.a[WIDTH-1];
                        neg_b_d  = signed_op && bus.b[WIDTH-1];
                        is_div_d = is_div_op;
                        acc_hi_d = '0;
                        acc_lo_d = is_div_op ? abs_a : abs_b;
                        opnd_d   = is_div_op ? abs_b : abs_a;
                        cnt_d    = SHW'(WIDTH-1);
                        state_d  = is_div_op ? DIV : MUL;
                    end else begin
                        c_d    = alu_res;
                        zero_d = (alu_res == '0);
                        ovf_d  = alu_ovf;
                        done_d = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_hi_d = mul_sum[WIDTH:1];
                acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = FIX;
            end
            DIV: begin
                acc_hi_d = div_ge ? div_diff : div_r[WIDTH-1:0];
                acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = FIX;
            end
            FIX: begin
                if (is_div_q) begin
                    hi_d = r_fix;
                    lo_d = q_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            is_div_q <= 1'b0;
            c_q      <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opnd_q   <= opnd_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            is_div_q <= is_div_d;
            c_q      <= c_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.c    = c_q;
    assign bus.zero = zero_q;
    assign bus.ovf  = ovf_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule
